muldiv_hilo_unit: RTL and testbench
===================================

# muldiv_hilo_unit

Iterative 32-bit multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS CPU. Accepts MULT/MULTU/DIV/DIVU from the decoded EX instruction, computes over a fixed number of cycles, and holds the 64-bit result in HI/LO. HI/LO feed the EX result-select mux for MFHI/MFLO. `busy` drives the hazard unit's stall.

## Interface
Parameters:
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin operation `op` on `a`, `b`; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  rs operand (multiplicand / dividend).
- b  in  32  rt operand (multiplier / divisor).
- cancel  in  1  abort the in-flight operation (pipeline flush).
- mthi  in  1  write `a` to HI.
- mtlo  in  1  write `a` to LO.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  operation in flight; the pipeline stalls MF*/MT*/start while high.
- done  out  1  one-cycle pulse when HI/LO take a new result.

## Operation
- States: IDLE, CALC, FIX. State is held in a register; busy = (state != IDLE).
- IDLE + start: latch the op; latch |a|, |b| for signed ops (raw for unsigned); latch result signs; clear the accumulator; set the counter to 31; go to CALC.
- CALC multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- CALC divide: restoring division, one quotient bit per cycle. Remainder is 33 bits wide so the subtract borrow is kept.
- CALC ends when the counter reaches 0 (32 iterations), then goes to FIX.
- FIX, signed multiply: negate the 64-bit product if sign(a) ^ sign(b).
- FIX, signed divide:
  - quotient negated if sign(a) ^ sign(b);
  - remainder takes the sign of a.
- FIX: write {hi,lo} ({remainder, quotient} for divide), pulse done, return to IDLE.
- Divide by zero (b == 0, either signedness): lo = 32'hFFFFFFFF, hi = a (raw input). The full 33-cycle latency still applies.
- Signed 0x80000000 / 0xFFFFFFFF: lo = 32'h80000000, hi = 0. This is the natural wrap; there is no trap.
- mthi/mtlo take effect only in IDLE with start low. If start is high in the same cycle, start wins and the MT write is dropped. MT writes while busy are ignored.
- cancel in CALC or FIX: return to IDLE next edge; HI/LO unchanged; no done pulse. cancel in IDLE has no effect. cancel takes priority over FIX completion.
- start while busy is ignored.

## Timing
- Reset: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0.
- start sampled at edge E0. busy is high from E0 through E33.
- CALC iterations occur on edges E1..E32. FIX completes at E33.
- HI/LO are valid and done is high in the cycle after E33; done is low otherwise.
- Back-to-back: start may be asserted in the cycle where done is high, since state is IDLE.
- mthi/mtlo latency: HI/LO are updated at the sampling edge and visible the next cycle.
- Reset asserted mid-operation: immediate return to reset values, regardless of the clock.

## Structure
- Shared header `muldiv_defs.vh`: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encodings, and the iteration count 32.
- One sub-module `muldiv_step`: combinational single-iteration datapath. It takes op, accumulator, remainder, and operand bits, and returns next accumulator/remainder plus a quotient bit.
- The top level contains the FSM, counter, sign-fix logic, and HI/LO registers.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 busy cycles: hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly one cycle.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 100/7, assert cancel at E10 -> busy low after E11, HI/LO keep prior values, no done. A new start at E12 gives lo=14, hi=2.
- mthi a=0x1234 in IDLE -> hi=0x1234 next cycle. mtlo asserted while busy -> ignored. mthi with start in the same cycle -> hi unchanged until the result.
- Assert rst at E15 of a MULT -> hi=lo=0, busy=0 immediately. Operation resumes normally after rst is released.

Source files
------------

// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared encodings and sizes for the iterative multiply/divide unit.
package muldiv_hilo_unit_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned ACC_W  = 2 * XLEN_W;
  localparam int unsigned ITERS  = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Start value of the iteration counter so that it reaches zero after ITERS steps.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS - 1);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_hilo_unit_pkg::*;
(
  input  logic              is_div,
  input  logic [ACC_W-1:0]  acc,
  input  logic [XLEN_W-1:0] rem,
  input  logic [XLEN_W-1:0] mcand,
  input  logic              mbit,
  input  logic              dbit,
  input  logic [XLEN_W-1:0] divisor,
  output logic [ACC_W-1:0]  acc_next_c,
  output logic [XLEN_W-1:0] rem_next_c,
  output logic              q_bit_c
);

  logic [XLEN_W:0] sum;
  logic [XLEN_W:0] rem_sh;
  logic            borrow;

  always_comb begin
    acc_next_c = acc;
    rem_next_c = rem;
    q_bit_c    = 1'b0;
    sum        = {1'b0, acc[ACC_W-1:XLEN_W]} + (mbit ? {1'b0, mcand} : (XLEN_W+1)'(0));
    // 33-bit shifted remainder keeps the top bit so the compare sees the true borrow.
    rem_sh     = {rem, dbit};
    borrow     = (rem_sh < {1'b0, divisor});
    if (is_div) begin
      q_bit_c    = ~borrow;
      rem_next_c = borrow ? rem_sh[XLEN_W-1:0] : XLEN_W'(rem_sh - {1'b0, divisor});
      acc_next_c = {acc[ACC_W-2:0], ~borrow};
    end else begin
      acc_next_c = {sum, acc[XLEN_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  input  logic            mthi,
  input  logic            mtlo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  state_e              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic                is_div;
  logic [XLEN_W-1:0]   opa, opb, a_raw, rem;
  logic [ACC_W-1:0]    acc;
  logic                neg_q, neg_r, b_zero;
  logic [ACC_W-1:0]    acc_next;
  logic [XLEN_W-1:0]   rem_next;
  logic                q_bit;
  logic                is_signed;
  logic [XLEN_W-1:0]   res_hi, res_lo;

  muldiv_step u_step (
    .is_div     (is_div),
    .acc        (acc),
    .rem        (rem),
    .mcand      (opa),
    .mbit       (opb[0]),
    .dbit       (opa[XLEN_W-1]),
    .divisor    (opb),
    .acc_next_c (acc_next),
    .rem_next_c (rem_next),
    .q_bit_c    (q_bit)
  );

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // cancel outranks both iteration and FIX completion.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CALC;
      S_CALC:  if (cancel) next_state = S_IDLE;
               else if (cnt == '0) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Sign fix-up; divide by zero returns all-ones quotient and the raw dividend.
  always_comb begin
    res_hi = acc[ACC_W-1:XLEN_W];
    res_lo = acc[XLEN_W-1:0];
    if (!is_div) begin
      {res_hi, res_lo} = neg_q ? ACC_W'(-acc) : acc;
    end else if (b_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = neg_r ? XLEN_W'(-rem) : rem;
      res_lo = neg_q ? XLEN_W'(-acc[XLEN_W-1:0]) : acc[XLEN_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      a_raw  <= '0;
      rem    <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (next_state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div <= op[1];
            opa    <= (is_signed && a[XLEN_W-1]) ? XLEN_W'(-a) : a;
            opb    <= (is_signed && b[XLEN_W-1]) ? XLEN_W'(-b) : b;
            a_raw  <= a;
            b_zero <= (b == '0);
            neg_q  <= is_signed && (a[XLEN_W-1] ^ b[XLEN_W-1]);
            neg_r  <= is_signed && a[XLEN_W-1];
            acc    <= '0;
            rem    <= '0;
            cnt    <= CNT_INIT;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        S_CALC: begin
          if (!cancel) begin
            acc <= acc_next;
            rem <= rem_next;
            if (is_div) opa <= {opa[XLEN_W-2:0], q_bit & 1'b0};
            else        opb <= {1'b0, opb[XLEN_W-1:1]};
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!cancel) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: ops, cancel, MT writes, async reset.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int passes = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model_hi, model_lo;

  muldiv_hilo_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'd0, ma};
    ub = {32'd0, mb};
    case (mop)
      2'b00:   r = 64'(sa * sb);
      2'b01:   r = ua * ub;
      2'b10:   r = (mb == 0) ? {ma, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (mb == 0) ? {ma, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one op, then waits for done, pops the scoreboard and checks latency, pulse width and HI/LO.
  task automatic run_op(input string name, input logic [1:0] mop, input logic [31:0] ma,
                        input logic [31:0] mb, input logic with_mthi, input logic busy_mtlo);
    int n;
    int busy_n;
    logic [63:0] exp;
    op = mop; a = ma; b = mb; start = 1'b1; mthi = with_mthi;
    sb_q.push_back(model(mop, ma, mb));
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = busy_mtlo; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    if (with_mthi) begin
      checks++;
      if (hi !== model_hi) $display("FAIL %s mthi_dropped hi=%h exp=%h", name, hi, model_hi);
      else passes++;
    end
    n = 0;
    busy_n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) busy_n++;
    end
    mtlo = 1'b0;
    checks++;
    if (n !== 33 || busy_n !== 33)
      $display("FAIL %s latency edges=%0d busy_cycles=%0d exp=33/33", name, n, busy_n);
    else passes++;
    checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s scoreboard_empty", name);
    end else begin
      exp = sb_q.pop_front();
      if ({hi, lo} !== exp) $display("FAIL %s result hi=%h lo=%h exp hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
      else passes++;
      model_hi = exp[63:32];
      model_lo = exp[31:0];
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL %s busy_at_done busy=%b exp=0", name, busy);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b0 || {hi, lo} !== {model_hi, model_lo})
      $display("FAIL %s done_pulse done=%b hi=%h lo=%h exp done=0", name, done, hi, lo);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; cancel = 0; mthi = 0; mtlo = 0; op = 0; a = 0; b = 0;
    model_hi = 0; model_lo = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0)
      $display("FAIL reset hi=%h lo=%h busy=%b done=%b exp all 0", hi, lo, busy, done);
    else passes++;
  endtask

  task automatic test_mult_div();
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) $display("FAIL multu_const hi=%h lo=%h exp fffffffe/00000001", hi, lo);
    else passes++;
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) $display("FAIL mult_const hi=%h lo=%h exp ffffffff/ffffffeb", hi, lo);
    else passes++;
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) $display("FAIL div_const hi=%h lo=%h exp ffffffff/fffffffd", hi, lo);
    else passes++;
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
    run_op("div_zero", 2'b10, 32'h8000_0005, 32'd0, 1'b0, 1'b0);
    run_op("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) $display("FAIL div_wrap_const hi=%h lo=%h exp 0/80000000", hi, lo);
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      run_op("random", rop, $urandom, (i == 3) ? 32'($urandom_range(1, 9)) : $urandom, 1'b0, 1'b0);
    end
  endtask

  task automatic test_cancel();
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== model_hi || lo !== model_lo)
      $display("FAIL cancel busy=%b done=%b hi=%h lo=%h exp 0/0/%h/%h", busy, done, hi, lo, model_hi, model_lo);
    else passes++;
    run_op("divu_after_cancel", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) $display("FAIL divu_const hi=%h lo=%h exp 2/14", hi, lo);
    else passes++;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo)
      $display("FAIL cancel_idle busy=%b hi=%h lo=%h", busy, hi, lo);
    else passes++;
  endtask

  task automatic test_mt();
    a = 32'h0000_1234; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    model_hi = 32'h0000_1234;
    checks++;
    if (hi !== 32'h0000_1234) $display("FAIL mthi hi=%h exp 00001234", hi);
    else passes++;
    a = 32'h0000_5678; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    model_lo = 32'h0000_5678;
    checks++;
    if (lo !== 32'h0000_5678 || hi !== 32'h0000_1234) $display("FAIL mtlo hi=%h lo=%h exp 00001234/00005678", hi, lo);
    else passes++;
    run_op("mtlo_busy", 2'b01, 32'd12345, 32'd678, 1'b0, 1'b1);
    run_op("mthi_start", 2'b00, 32'hFFFF_0001, 32'h0000_0003, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    op = 2'b00; a = 32'h0001_0000; b = 32'h0000_0010; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    #2 rst = 1'b1;
    #1;
    model_hi = 0; model_lo = 0;
    checks++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0)
      $display("FAIL async_reset hi=%h lo=%h busy=%b done=%b exp 0", hi, lo, busy, done);
    else passes++;
    tick();
    rst = 1'b0;
    tick();
    run_op("after_reset", 2'b00, 32'h0001_0000, 32'hFFFF_FFF0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    sb_q.push_back(model(2'b01, 32'd3, 32'd5));
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) tick();
    void'(sb_q.pop_front());
    checks++;
    if (done !== 1'b1 || lo !== 32'd15) $display("FAIL b2b_first done=%b lo=%h exp 1/0000000f", done, lo);
    else passes++;
    model_hi = 0; model_lo = 32'd15;
    run_op("b2b_second", 2'b10, 32'hFFFF_FF9C, 32'd9, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult_div();
    test_cancel();
    test_mt();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
